// File: rtl/mod_updown_counter.sv
// Modulo up/down counter for one clock/calendar digit field. Counts ticks in
// run mode, steps on inc/dec buttons with hold-to-repeat in set mode, and
// emits registered carry/borrow pulses to chain into the neighbouring field.
module mod_updown_counter #(
   parameter int WIDTH         = 7,
   parameter int MIN_VAL       = 0,
   parameter int MAX_VAL       = 99,
   parameter int RESET_VAL     = 0,
   parameter int USE_LIM_IN    = 0,
   parameter int REPEAT_DELAY  = 50,
   parameter int REPEAT_PERIOD = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_cnt,
   input  logic             tick,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] lim_in,
   output logic [WIDTH-1:0] count,
   output logic             carry,
   output logic             borrow,
   output logic             at_max,
   output logic             at_min
);

   localparam int TimerMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TimerW   = $clog2(TimerMax + 1);

   localparam logic [WIDTH-1:0]  MinV       = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0]  MaxV       = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0]  ResetV     = WIDTH'(RESET_VAL);
   localparam logic [TimerW-1:0] DelayLast  = TimerW'(REPEAT_DELAY - 1);
   localparam logic [TimerW-1:0] PeriodLast = TimerW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } state_t;

   state_t            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              incPrev_q, decPrev_q;
   logic [WIDTH-1:0]  count_q, count_d;
   logic              carry_q, carry_d;
   logic              borrow_q, borrow_d;

   logic [WIDTH-1:0]  effMax;
   logic [WIDTH-1:0]  loadClamped;
   logic [WIDTH-1:0]  loadFloored;
   logic              btn;
   logic              btnRise;
   logic              btnHeld;
   logic              btnStep;
   logic              stepUp;
   logic              stepDn;

   assign effMax      = (USE_LIM_IN != 0) ? lim_in : MaxV;
   assign loadFloored = (load_val > MinV) ? load_val : MinV;
   assign loadClamped = (loadFloored > effMax) ? effMax : loadFloored;

   // A valid press is exactly one of inc/dec. "Held" means the very same
   // button pattern as last cycle, so a direction swap counts as a release.
   assign btn     = inc ^ dec;
   assign btnRise = btn && !(incPrev_q ^ decPrev_q);
   assign btnHeld = btn && (inc == incPrev_q) && (dec == decPrev_q);

   // Repeat FSM: first step on press, then after a long delay, then periodically.
   // Run mode parks it in IDLE; a load cycle freezes it.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      btnStep = 1'b0;
      if (enable_cnt) begin
         state_d = IDLE;
         timer_d = '0;
      end else if (!load) begin
         case (state_q)
            IDLE: begin
               if (btnRise) begin
                  btnStep = 1'b1;
                  timer_d = '0;
                  state_d = DELAY;
               end
            end
            DELAY: begin
               if (!btnHeld) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (timer_q == DelayLast) begin
                  btnStep = 1'b1;
                  timer_d = '0;
                  state_d = REPEAT;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            REPEAT: begin
               if (!btnHeld) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (timer_q == PeriodLast) begin
                  btnStep = 1'b1;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   // FSM state, repeat timer and button edge registers. The edge registers
   // follow the buttons in every mode so a hold carried across a mode change
   // never looks like a fresh press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         incPrev_q <= 1'b0;
         decPrev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         incPrev_q <= inc;
         decPrev_q <= dec;
      end
   end

   assign stepUp = enable_cnt ? tick : (btnStep && inc);
   assign stepDn = !enable_cnt && btnStep && !inc;

   // Next count with priority load, then pulling an over-limit value back to
   // the limit, then stepping. Wrap pulses are raised only by a real wrap.
   always_comb begin
      count_d  = count_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      if (load) begin
         count_d = loadClamped;
      end else if (count_q > effMax) begin
         count_d = effMax;
      end else if (stepUp) begin
         if (count_q >= effMax) begin
            count_d = MinV;
            carry_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end else if (stepDn) begin
         if (count_q == MinV) begin
            count_d  = effMax;
            borrow_d = 1'b1;
         end else begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Count value and the registered carry/borrow pulses that accompany it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= ResetV;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
      end
   end

   assign count  = count_q;
   assign carry  = carry_q;
   assign borrow = borrow_q;
   assign at_max = (count_q == effMax);
   assign at_min = (count_q == MinV);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: two instances (fixed limit 0..99, and runtime
// limit with minimum 1 and short repeat timings) driven by the same inputs and
// compared every cycle against a behavioural model of the counter rules.
module tb_mod_updown_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       enableCnt, tick, inc, dec, load;
   logic [7:0] loadVal, limIn;

   logic [7:0] countA, countB;
   logic       carryA, borrowA, atMaxA, atMinA;
   logic       carryB, borrowB, atMaxB, atMinB;

   int checks = 0;
   int errors = 0;
   int carrySeen;

   int mCount  [2];
   int mHeld   [2];
   int mCarry  [2];
   int mBorrow [2];
   int pInc, pDec;

   always #5 clk = ~clk;

   mod_updown_counter #(
      .WIDTH(8), .MIN_VAL(0), .MAX_VAL(99), .RESET_VAL(0), .USE_LIM_IN(0),
      .REPEAT_DELAY(50), .REPEAT_PERIOD(10)
   ) dutA (
      .clk(clk), .rst(rst), .enable_cnt(enableCnt), .tick(tick), .inc(inc), .dec(dec),
      .load(load), .load_val(loadVal), .lim_in(limIn), .count(countA), .carry(carryA),
      .borrow(borrowA), .at_max(atMaxA), .at_min(atMinA)
   );

   mod_updown_counter #(
      .WIDTH(8), .MIN_VAL(1), .MAX_VAL(99), .RESET_VAL(1), .USE_LIM_IN(1),
      .REPEAT_DELAY(5), .REPEAT_PERIOD(3)
   ) dutB (
      .clk(clk), .rst(rst), .enable_cnt(enableCnt), .tick(tick), .inc(inc), .dec(dec),
      .load(load), .load_val(loadVal), .lim_in(limIn), .count(countB), .carry(carryB),
      .borrow(borrowB), .at_max(atMaxB), .at_min(atMinB)
   );

   function automatic int minOf(int k);
      return (k == 0) ? 0 : 1;
   endfunction

   function automatic int resetOf(int k);
      return (k == 0) ? 0 : 1;
   endfunction

   function automatic int delayOf(int k);
      return (k == 0) ? 50 : 5;
   endfunction

   function automatic int periodOf(int k);
      return (k == 0) ? 10 : 3;
   endfunction

   function automatic int limitOf(int k);
      return (k == 0) ? 99 : int'(limIn);
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reset state of the model: reset value, no pulses, no press in progress.
   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mCount[k]  = resetOf(k);
         mHeld[k]   = 0;
         mCarry[k]  = 0;
         mBorrow[k] = 0;
      end
      pInc = 0;
      pDec = 0;
   endtask

   // One clock of the model. mHeld is the number of consecutive cycles the
   // current press has lasted (0 = no press); a step is due on the first cycle
   // of the press and then on cycle DELAY+1, DELAY+1+PERIOD, ...
   task automatic modelStep();
      int  btn, prevBtn, pressed, same, stepReq, up, em, mn, lv;
      btn     = int'(inc) ^ int'(dec);
      prevBtn = pInc ^ pDec;
      pressed = (btn == 1 && prevBtn == 0) ? 1 : 0;
      same    = (btn == 1 && int'(inc) == pInc && int'(dec) == pDec) ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
         em      = limitOf(k);
         mn      = minOf(k);
         stepReq = 0;
         up      = int'(inc);
         if (enableCnt) begin
            mHeld[k] = 0;
            stepReq  = int'(tick);
            up       = 1;
         end else if (!load) begin
            if (mHeld[k] == 0) begin
               if (pressed == 1) begin
                  stepReq  = 1;
                  mHeld[k] = 1;
               end
            end else if (same == 1) begin
               mHeld[k]++;
               if (mHeld[k] >= delayOf(k) + 1 &&
                   ((mHeld[k] - delayOf(k) - 1) % periodOf(k)) == 0)
                  stepReq = 1;
            end else begin
               mHeld[k] = 0;
            end
         end
         mCarry[k]  = 0;
         mBorrow[k] = 0;
         if (load) begin
            lv = int'(loadVal);
            if (lv < mn) lv = mn;
            if (lv > em) lv = em;
            mCount[k] = lv;
         end else if (mCount[k] > em) begin
            mCount[k] = em;
         end else if (stepReq == 1) begin
            if (up == 1) begin
               if (mCount[k] >= em) begin
                  mCount[k] = mn;
                  mCarry[k] = 1;
               end else begin
                  mCount[k] = mCount[k] + 1;
               end
            end else begin
               if (mCount[k] == mn) begin
                  mCount[k]  = em;
                  mBorrow[k] = 1;
               end else begin
                  mCount[k] = mCount[k] - 1;
               end
            end
         end
      end
      pInc = int'(inc);
      pDec = int'(dec);
   endtask

   task automatic checkAll();
      checkOutput("A.count",  int'(countA),  mCount[0]);
      checkOutput("A.carry",  int'(carryA),  mCarry[0]);
      checkOutput("A.borrow", int'(borrowA), mBorrow[0]);
      checkOutput("A.atMax",  int'(atMaxA),  (mCount[0] == limitOf(0)) ? 1 : 0);
      checkOutput("A.atMin",  int'(atMinA),  (mCount[0] == minOf(0)) ? 1 : 0);
      checkOutput("B.count",  int'(countB),  mCount[1]);
      checkOutput("B.carry",  int'(carryB),  mCarry[1]);
      checkOutput("B.borrow", int'(borrowB), mBorrow[1]);
      checkOutput("B.atMax",  int'(atMaxB),  (mCount[1] == limitOf(1)) ? 1 : 0);
      checkOutput("B.atMin",  int'(atMinB),  (mCount[1] == minOf(1)) ? 1 : 0);
   endtask

   // Drive one cycle of inputs on the falling edge, advance the model, and
   // compare both instances shortly after the following rising edge.
   task automatic applyStimulus(input bit en, input bit tk, input bit i, input bit d,
                                input bit ld, input logic [7:0] lv, input logic [7:0] lim);
      @(negedge clk);
      rst       = 1'b0;
      enableCnt = en;
      tick      = tk;
      inc       = i;
      dec       = d;
      load      = ld;
      loadVal   = lv;
      limIn     = lim;
      modelStep();
      @(posedge clk);
      #1;
      if (carryA) carrySeen++;
      checkAll();
   endtask

   // Asynchronous reset asserted between clock edges and checked before any
   // edge arrives; the next applyStimulus releases it.
   task automatic assertReset();
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkAll();
   endtask

   initial begin
      int segLeft;
      int btnSel;
      bit en;
      logic [7:0] lim;
      rst       = 1'b0;
      enableCnt = 1'b0;
      tick      = 1'b0;
      inc       = 1'b0;
      dec       = 1'b0;
      load      = 1'b0;
      loadVal   = 8'd0;
      limIn     = 8'd99;
      carrySeen = 0;

      @(negedge clk);
      assertReset();

      // Run mode, tick every fourth clock: 100 ticks take the fixed-limit
      // counter through 0..99 and back to 0 with exactly one carry.
      for (int c = 0; c < 400; c++)
         applyStimulus(1'b1, (c % 4) == 3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd99);
      checkOutput("t1.countWrapped", int'(countA), 0);
      checkOutput("t1.carryOnWrap", int'(carryA), 1);
      checkOutput("t1.carryCount", carrySeen, 1);

      // Set mode single presses across the wrap point.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd99);
      checkOutput("t2.decWrap", int'(countA), 99);
      checkOutput("t2.borrow", int'(borrowA), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd99);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd99);
      checkOutput("t2.incWrap", int'(countA), 0);
      checkOutput("t2.carry", int'(carryA), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd99);

      // Hold inc for 80 clocks: steps on clocks 1, 51, 61 and 71.
      for (int c = 0; c < 80; c++)
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd99);
      checkOutput("t3.holdSteps", int'(countA), 4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd99);

      // Runtime limit lowered below the count, then a wrap from the new limit.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd31, 8'd99);
      checkOutput("t4.load31", int'(countB), 31);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd28);
      checkOutput("t4.pulledToLim", int'(countB), 28);
      checkOutput("t4.noCarry", int'(carryB), 0);
      checkOutput("t4.noBorrow", int'(borrowB), 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd28);
      checkOutput("t4.wrapToMin", int'(countB), 1);
      checkOutput("t4.carry", int'(carryB), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd99);

      // Load beats a simultaneous press and is clamped; both buttons do nothing.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd150, 8'd99);
      checkOutput("t5.loadClamp", int'(countA), 99);
      checkOutput("t5.loadNoCarry", int'(carryA), 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd99);
      checkOutput("t5.bothButtons", int'(countA), 99);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd99);

      // Reset while auto-repeating at 42.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd40, 8'd99);
      for (int c = 0; c < 52; c++)
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd99);
      checkOutput("t6.beforeReset", int'(countA), 42);
      assertReset();
      checkOutput("t6.resetCount", int'(countA), 0);
      checkOutput("t6.resetCarry", int'(carryA), 0);
      for (int c = 0; c < 4; c++)
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd99);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd99);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd99);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd99);

      // Randomised mix of modes, button holds, loads and limit changes.
      segLeft = 0;
      btnSel  = 0;
      en      = 1'b0;
      lim     = 8'd60;
      for (int c = 0; c < 4000; c++) begin
         if (segLeft == 0) begin
            segLeft = $urandom_range(1, 70);
            btnSel  = $urandom_range(0, 3);
         end
         segLeft--;
         if ($urandom_range(0, 149) == 0) en = ~en;
         if ($urandom_range(0, 59) == 0) lim = 8'($urandom_range(1, 200));
         if ($urandom_range(0, 999) == 0) assertReset();
         applyStimulus(en, $urandom_range(0, 2) == 0, btnSel[0], btnSel[1],
                       $urandom_range(0, 49) == 0, 8'($urandom_range(0, 255)), lim);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
